// File: rtl/piso_ser.sv
// piso_ser -- parallel-in / serial-out serializer.
//
// Accepts a WIDTH-bit word with a valid/ready handshake and shifts it out
// MSB first, one registered bit per clock, flagging the frame with
// sout_valid and marking its first bit with sof. A word offered during the
// final bit cycle of a frame is taken immediately, so frames can run
// back-to-back with no idle gap.
//
// Optional build macro:
//   PISO_SER_PARITY_EN  - append one even-parity bit (XOR of the data bits)
//                         after din[0]; the frame becomes WIDTH+1 bits.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   din        in   [WIDTH-1:0] parallel word
//   din_valid  in   din holds a word offered for transfer
//   din_ready  out  word is accepted on this edge when din_valid=1
//   sout       out  registered serial bit
//   sout_valid out  sout carries a frame bit this cycle
//   sof        out  first bit of a frame
//   busy       out  a frame is in progress (state not IDLE)
module piso_ser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_SER_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sof_q, sof_d;
  // Low from reset until the first clock edge after release, so din_ready
  // stays 0 while reset is held.
  logic             rdy_en_q, rdy_en_d;
`ifdef PISO_SER_PARITY_EN
  logic             par_q, par_d;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  logic ready_s;
  logic accept_s;

  // Decide whether the current cycle can take a new word.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_IDLE:   ready_s = 1'b1;
`ifdef PISO_SER_PARITY_EN
      // With parity the final bit cycle is the PARITY cycle, not din[0].
      ST_SHIFT:  ready_s = 1'b0;
      ST_PARITY: ready_s = 1'b1;
`else
      ST_SHIFT:  ready_s = (cnt_q == CNT_ZERO);
`endif
      default:   ready_s = 1'b0;
    endcase
  end

  assign din_ready = rdy_en_q & ready_s;
  assign accept_s  = din_valid & din_ready;

  // Next-state, shift and output-bit computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    sof_d        = 1'b0;
    rdy_en_d     = 1'b1;
`ifdef PISO_SER_PARITY_EN
    par_d        = par_q;
`endif
    if (accept_s) begin
      // MSB goes straight to the output register; the rest waits in shreg.
      state_d      = ST_SHIFT;
      cnt_d        = CNT_LOAD;
      shreg_d      = {din[WIDTH-2:0], 1'b0};
      sout_d       = din[WIDTH-1];
      sout_valid_d = 1'b1;
      sof_d        = 1'b1;
`ifdef PISO_SER_PARITY_EN
      par_d        = even_parity(din);
`endif
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d        = cnt_q - CNT_ONE;
            sout_d       = shreg_q[WIDTH-1];
            shreg_d      = {shreg_q[WIDTH-2:0], 1'b0};
            sout_valid_d = 1'b1;
          end else begin
`ifdef PISO_SER_PARITY_EN
            state_d      = ST_PARITY;
            sout_d       = par_q;
            sout_valid_d = 1'b1;
`else
            state_d      = ST_IDLE;
`endif
          end
        end
`ifdef PISO_SER_PARITY_EN
        ST_PARITY: state_d = ST_IDLE;
`endif
        ST_IDLE:   state_d = ST_IDLE;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          shreg_d = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      shreg_q      <= {WIDTH{1'b0}};
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      rdy_en_q     <= 1'b0;
`ifdef PISO_SER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sof_q        <= sof_d;
      rdy_en_q     <= rdy_en_d;
`ifdef PISO_SER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sof        = sof_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_ser.sv
// Testbench for piso_ser (WIDTH=4). A queue-based frame model predicts the
// serial stream; a compare process checks every output each cycle, and
// directed scenarios add literal expectations on the captured stream.
module tb_piso_ser;

  localparam int W = 4;
`ifdef PISO_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = 4'h0;
  logic         din_valid = 1'b0;
  logic         din_ready, sout, sout_valid, sof, busy;

  piso_ser #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sof       (sof),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bits of the current frame still to appear, front = bit on sout now.
  bit mq[$];
  bit m_sof    = 1'b0;
  bit m_rdy_en = 1'b0;

  logic [15:0] capv;
  logic [15:0] capsof;
  int          capn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_rdy_en && (mq.size() <= 1);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_sof    = 1'b0;
    m_rdy_en = 1'b0;
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    bit acc;
    if (!rst) begin
      model_reset();
    end else begin
      acc = din_valid && m_ready();
      if (acc) begin
        mq.delete();
        for (int i = W - 1; i >= 0; i--) mq.push_back(din[i]);
        if (PAR == 1) mq.push_back(^din);
        m_sof = 1'b1;
      end else begin
        if (mq.size() > 0) void'(mq.pop_front());
        m_sof = 1'b0;
      end
      m_rdy_en = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, update the model, capture valid serial bits.
  task automatic step(input logic v, input logic [W-1:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
    if (sout_valid === 1'b1) begin
      capv   = {capv[14:0], sout};
      capsof = {capsof[14:0], sof};
      capn++;
    end
  endtask

  task automatic cap_clear();
    capv   = 16'h0;
    capsof = 16'h0;
    capn   = 0;
  endtask

  // Per-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("din_ready",  {31'd0, din_ready},  {31'd0, m_ready()});
      chk("sout_valid", {31'd0, sout_valid}, {31'd0, (mq.size() > 0)});
      chk("sout",       {31'd0, sout},       {31'd0, ((mq.size() > 0) ? mq[0] : 1'b0)});
      chk("sof",        {31'd0, sof},        {31'd0, m_sof});
      chk("busy",       {31'd0, busy},       {31'd0, (mq.size() > 0)});
    end
  end

  logic [15:0] exp_bits;
  logic [15:0] exp_sof;

  initial begin
    cap_clear();
    @(negedge clk);
    #1;

    // Reset held with a word offered: nothing accepted, all outputs low.
    repeat (2) step(1'b1, 4'hF);
    chk("rst_ready", {31'd0, din_ready}, 32'd0);
    chk("rst_valid", {31'd0, sout_valid}, 32'd0);
    rst = 1'b1;
    step(1'b1, 4'hF);
    chk("rel_ready", {31'd0, din_ready}, 32'd1);
    chk("rel_noacc", {31'd0, sout_valid}, 32'd0);
    step(1'b0, 4'h0);

    // Single frame 1010, checked also as a chained sipo's contents.
    cap_clear();
    step(1'b1, 4'b1010);
    repeat (W + PAR + 1) step(1'b0, 4'h0);
`ifdef PISO_SER_PARITY_EN
    exp_bits = 16'b10100;  exp_sof = 16'b10000;
`else
    exp_bits = 16'b1010;   exp_sof = 16'b1000;
`endif
    chk("single_bits", {16'd0, capv}, {16'd0, exp_bits});
    chk("single_sof",  {16'd0, capsof}, {16'd0, exp_sof});
    chk("single_len",  capn, W + PAR);
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Back-to-back frames with din_valid held.
    cap_clear();
    step(1'b1, 4'b1100);
    repeat (W + PAR) step(1'b1, 4'b0011);
    repeat (W + PAR + 1) step(1'b0, 4'h0);
`ifdef PISO_SER_PARITY_EN
    exp_bits = 16'b1100000110;  exp_sof = 16'b1000010000;
`else
    exp_bits = 16'b11000011;    exp_sof = 16'b10001000;
`endif
    chk("b2b_bits", {16'd0, capv}, {16'd0, exp_bits});
    chk("b2b_sof",  {16'd0, capsof}, {16'd0, exp_sof});
    chk("b2b_len",  capn, 2 * (W + PAR));

    // Backpressure: din changes during a frame are ignored.
    cap_clear();
    step(1'b1, 4'b0001);
    repeat (W + PAR) step(1'b1, 4'b1111);
    repeat (W + PAR + 1) step(1'b0, 4'h0);
`ifdef PISO_SER_PARITY_EN
    exp_bits = 16'b0001111110;
`else
    exp_bits = 16'b00011111;
`endif
    chk("bp_bits", {16'd0, capv}, {16'd0, exp_bits});
    chk("bp_len",  capn, 2 * (W + PAR));

    // Mid-frame reset after two bits of 1011.
    cap_clear();
    step(1'b1, 4'b1011);
    step(1'b0, 4'h0);
    chk("mid_pre_len",  capn, 2);
    chk("mid_pre_bits", {16'd0, capv}, 32'b10);
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_valid", {31'd0, sout_valid}, 32'd0);
    chk("mid_ready", {31'd0, din_ready}, 32'd0);
    chk("mid_busy",  {31'd0, busy}, 32'd0);
    cap_clear();
    step(1'b0, 4'h0);
    rst = 1'b1;
    repeat (6) step(1'b0, 4'h0);
    chk("mid_after_len", capn, 0);

`ifdef PISO_SER_PARITY_EN
    // Parity bit values.
    cap_clear();
    step(1'b1, 4'b0111);
    repeat (6) step(1'b0, 4'h0);
    chk("par_0111_bits", {16'd0, capv}, 32'b01111);
    chk("par_0111_len",  capn, 5);
    cap_clear();
    step(1'b1, 4'b0110);
    repeat (6) step(1'b0, 4'h0);
    chk("par_0110_bits", {16'd0, capv}, 32'b01100);
    chk("par_0110_len",  capn, 5);
`endif

    // Mixed traffic, checked by the per-cycle compare.
    repeat (80) step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    repeat (W + PAR + 2) step(1'b0, 4'h0);
    chk("end_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_ser.md
PISO_SER -- requirements
Module: piso_ser

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data word width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port din_valid  input  1  din holds a word offered for transfer.
REQ-006 SHALL have port din_ready  output  1  block accepts din on this edge if din_valid=1.
REQ-007 SHALL have port sout  output  1  registered serial data bit, the "in" of the downstream sipo.
REQ-008 SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 SHALL have port sof  output  1  high only during the first bit cycle of each frame.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, SHIFT, PARITY (PARITY present only per REQ-025).
REQ-012 SHALL accept a word on a rising edge where din_valid=1 and din_ready=1; no other edge loads din.
REQ-013 SHALL drive din_ready=1 in IDLE and during the final bit cycle of a frame; 0 otherwise.
REQ-014 SHALL transmit MSB first: word accepted at edge N puts din[WIDTH-1] on sout in cycle N+1, din[0] in cycle N+WIDTH.
REQ-015 SHALL hold sout_valid=1 for exactly WIDTH consecutive cycles per frame (WIDTH+1 with parity).
REQ-016 SHALL assert sof in cycle N+1 only.
REQ-017 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits, loaded with WIDTH-1 on accept, decremented per bit; last bit when counter=0.
REQ-018 SHALL, on accept during the final bit cycle (back-to-back), start the next frame in the immediately following cycle with no idle gap and sof=1.
REQ-019 SHALL return to IDLE after the final bit if no word is accepted, with sout=0, sout_valid=0, sof=0.
REQ-020 SHALL ignore din and din_valid changes while din_ready=0; the internal shift register alone sources sout.
REQ-021 SHALL not generate X on any output when din_valid=0 indefinitely.

Reset
REQ-022 SHALL, while rst=0, immediately force state=IDLE, counter=0, shift register=0, sout=0, sout_valid=0, sof=0, busy=0, din_ready=0.
REQ-023 SHALL, on rst asserted mid-frame, abandon the frame; no remaining bits are sent after release.
REQ-024 SHALL drive din_ready=1 from the first rising edge after rst deassertion.

Configuration
REQ-025 SHALL, when macro PISO_SER_PARITY_EN is defined, append one even-parity bit (XOR of the WIDTH data bits) in state PARITY after din[0], with sout_valid=1 and din_ready=1 in that cycle.
REQ-026 SHALL, without PISO_SER_PARITY_EN, contain no PARITY state or parity logic; the frame is WIDTH bits and the final bit cycle is the din[0] cycle.

Verification
REQ-027 SHALL verify reset: rst=0 for 2 cycles with din_valid=1 -> all outputs 0, no accept; after release din_ready=1 on the next edge.
REQ-028 SHALL verify single frame: WIDTH=4, din=4'b1010 accepted at edge N -> sout=1,0,1,0 in cycles N+1..N+4, sof only at N+1, then IDLE; a chained sipo holds q=4'b1010 after N+4.
REQ-029 SHALL verify back-to-back: 4'b1100 then 4'b0011 with din_valid held -> 8 contiguous valid bits 1,1,0,0,0,0,1,1, sof at bits 1 and 5.
REQ-030 SHALL verify backpressure: din changed to 4'b1111 during SHIFT of 4'b0001 -> sout still 0,0,0,1; 4'b1111 accepted only at final bit cycle.
REQ-031 SHALL verify mid-frame reset: rst=0 after 2 bits of 4'b1011 -> sout_valid=0 at once, no further bits of 4'b1011 after release.
REQ-032 SHALL verify PISO_SER_PARITY_EN: din=4'b0111 -> sout 0,1,1,1 then parity 1, sout_valid 5 cycles; din=4'b0110 -> parity 0.
